// File: rtl/pc_stack_gen_pkg.sv
// Shared PSQ return-stack definitions: default geometry and the operation decode.
package pc_stack_gen_pkg;

  localparam int PCSTK_DW_DEF    = 14;
  localparam int PCSTK_DEPTH_DEF = 16;
  localparam int PCSTK_AF_DEF    = 14;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPL,
    OP_CLR
  } stk_op_e;

  // push+pop on an empty stack has no top to replace, so it degrades to a plain push
  function automatic stk_op_e op_decode(input logic push, input logic pop,
                                        input logic clr, input logic is_empty);
    if (clr)          return OP_CLR;
    if (push && pop)  return is_empty ? OP_PUSH : OP_REPL;
    if (push)         return OP_PUSH;
    if (pop)          return OP_POP;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/pc_stack_gen_if.sv
// Control/status bundle between PSQ call/return logic (master) and the PC stack (slave).
interface pc_stack_gen_if
  import pc_stack_gen_pkg::*;
#(
  parameter int DW    = PCSTK_DW_DEF,
  parameter int DEPTH = PCSTK_DEPTH_DEF
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          ckenb;
  logic          push;
  logic          pop;
  logic          clr;
  logic [DW-1:0] din;
  logic [DW-1:0] top;
  logic [DW-1:0] ntop;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          has1;
  logic          almost_full;
  logic          ovf_err;
  logic          unf_err;

  modport master (
    output ckenb, push, pop, clr, din,
    input  top, ntop, count, empty, full, has1, almost_full, ovf_err, unf_err
  );

  modport slave (
    input  ckenb, push, pop, clr, din,
    output top, ntop, count, empty, full, has1, almost_full, ovf_err, unf_err
  );
endinterface

// File: rtl/pc_stack_ram.sv
// DEPTH x DW register file, one sync write port, combinational reads (third with PCSTK_DBG_EN).
module pc_stack_ram #(
  parameter int DW    = 14,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          PCSCLK,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
`ifdef PCSTK_DBG_EN
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd2,
`endif
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge PCSCLK)
    if (we) mem[wa] <= wd;

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];
`ifdef PCSTK_DBG_EN
  assign rd2 = mem[ra2];
`endif
endmodule

// File: rtl/pc_stack_gen.sv
// PSQ return-address stack: count/error state, op decode, flag decode, top/ntop masking.
// Optional debug read port of the storage under PCSTK_DBG_EN.
module pc_stack_gen
  import pc_stack_gen_pkg::*;
#(
  parameter int DW       = PCSTK_DW_DEF,
  parameter int DEPTH    = PCSTK_DEPTH_DEF,
  parameter int AF_LEVEL = PCSTK_AF_DEF
) (
  input  logic                     PCSCLK,
  input  logic                     T_RST,
`ifdef PCSTK_DBG_EN
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [DW-1:0]            dbg_data,
`endif
  pc_stack_gen_if.slave            sif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);

  stk_op_e       op;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ovf_q, ovf_nxt, unf_q, unf_nxt;
  logic          empty_w, full_w;
  logic [AW-1:0] ptr, top_a, ntop_a, wa;
  logic          we, ram_we;
  logic [DW-1:0] rd_top, rd_ntop;

  assign empty_w = (cnt == '0);
  assign full_w  = (cnt == CW'(DEPTH));
  // addresses wrap mod DEPTH; out-of-range cases are masked on the read side
  assign ptr     = cnt[AW-1:0];
  assign top_a   = ptr - AW'(1);
  assign ntop_a  = ptr - AW'(2);

  always_comb begin
    op      = op_decode(sif.push, sif.pop, sif.clr, empty_w);
    cnt_nxt = cnt;
    ovf_nxt = ovf_q;
    unf_nxt = unf_q;
    we      = 1'b0;
    wa      = ptr;
    case (op)
      OP_CLR: begin
        cnt_nxt = '0;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
      end
      OP_PUSH: begin
        if (full_w) ovf_nxt = 1'b1;
        else begin
          we      = 1'b1;
          cnt_nxt = cnt + CW'(1);
        end
      end
      OP_POP: begin
        if (empty_w) unf_nxt = 1'b1;
        else         cnt_nxt = cnt - CW'(1);
      end
      OP_REPL: begin
        we = 1'b1;
        wa = top_a;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCSCLK or posedge T_RST) begin
    if (T_RST) begin
      cnt   <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!sif.ckenb) begin
      cnt   <= cnt_nxt;
      ovf_q <= ovf_nxt;
      unf_q <= unf_nxt;
    end
  end

  // storage has no reset, so a write racing reset must be suppressed here
  assign ram_we = we & ~sif.ckenb & ~T_RST;

  pc_stack_ram #(.DW(DW), .DEPTH(DEPTH)) u_ram (
    .PCSCLK (PCSCLK),
    .we     (ram_we),
    .wa     (wa),
    .wd     (sif.din),
    .ra0    (top_a),
    .ra1    (ntop_a),
`ifdef PCSTK_DBG_EN
    .ra2    (dbg_addr),
    .rd2    (dbg_data),
`endif
    .rd0    (rd_top),
    .rd1    (rd_ntop)
  );

  assign sif.count       = cnt;
  assign sif.empty       = empty_w;
  assign sif.full        = full_w;
  assign sif.has1        = (cnt == CW'(1));
  assign sif.almost_full = (cnt >= CW'(AF_LEVEL));
  assign sif.ovf_err     = ovf_q;
  assign sif.unf_err     = unf_q;
  assign sif.top         = empty_w ? '0 : rd_top;
  assign sif.ntop        = (cnt < CW'(2)) ? '0 : rd_ntop;
endmodule

// File: tb/tb_pc_stack_gen.sv
// Self-checking bench for pc_stack_gen: vector table plus multi-cycle corner sequences.
module tb_pc_stack_gen;
  localparam int DW = 14, DEPTH = 16, AF = 14;

  logic PCSCLK = 1'b0;
  logic T_RST  = 1'b1;
  always #5 PCSCLK = ~PCSCLK;

  pc_stack_gen_if #(.DW(DW), .DEPTH(DEPTH)) sif ();

`ifdef PCSTK_DBG_EN
  logic [3:0]    dbg_addr = '0;
  logic [DW-1:0] dbg_data;
`endif

  pc_stack_gen #(.DW(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .PCSCLK   (PCSCLK),
    .T_RST    (T_RST),
`ifdef PCSTK_DBG_EN
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
`endif
    .sif      (sif)
  );

  typedef struct {
    int cnt, top, ntop, ovf, unf;
  } exp_t;

  typedef struct {
    int pu, po, cl, ce, din;
    int cnt, top, ntop, ovf, unf;
  } vec_t;

  exp_t sbq[$];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".count"},       int'(sif.count),       e.cnt);
    chk({tag, ".top"},         int'(sif.top),         e.top);
    chk({tag, ".ntop"},        int'(sif.ntop),        e.ntop);
    chk({tag, ".empty"},       int'(sif.empty),       int'(e.cnt == 0));
    chk({tag, ".full"},        int'(sif.full),        int'(e.cnt == DEPTH));
    chk({tag, ".has1"},        int'(sif.has1),        int'(e.cnt == 1));
    chk({tag, ".almost_full"}, int'(sif.almost_full), int'(e.cnt >= AF));
    chk({tag, ".ovf_err"},     int'(sif.ovf_err),     e.ovf);
    chk({tag, ".unf_err"},     int'(sif.unf_err),     e.unf);
  endtask

  task automatic drive(input int pu, po, cl, ce, d);
    sif.push  = (pu != 0);
    sif.pop   = (po != 0);
    sif.clr   = (cl != 0);
    sif.ckenb = (ce != 0);
    sif.din   = DW'(d);
  endtask

  // one clock: drive, queue expectation, sample 1 time unit after the edge
  task automatic step(input string tag, input int pu, po, cl, ce, d,
                      input int ec, et, en, eo, eu);
    exp_t e;
    drive(pu, po, cl, ce, d);
    e = '{ec, et, en, eo, eu};
    sbq.push_back(e);
    @(posedge PCSCLK);
    #1;
    if (sbq.size() == 0) chk({tag, ".scoreboard"}, 0, 1);
    else begin
      e = sbq.pop_front();
      check_out(tag, e);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  vec_t tbl[19];

  initial begin
    exp_t z;
    z = '{0, 0, 0, 0, 0};
    //           pu po cl ce din      cnt top      ntop     ovf unf
    tbl[0]  = '{1, 0, 0, 0, 'h0123,  1, 'h0123,  'h0000,  0, 0};
    tbl[1]  = '{1, 0, 0, 0, 'h0456,  2, 'h0456,  'h0123,  0, 0};
    tbl[2]  = '{1, 0, 0, 0, 'h0789,  3, 'h0789,  'h0456,  0, 0};
    tbl[3]  = '{0, 1, 0, 0, 'h0000,  2, 'h0456,  'h0123,  0, 0};
    tbl[4]  = '{0, 1, 0, 0, 'h0000,  1, 'h0123,  'h0000,  0, 0};
    tbl[5]  = '{0, 1, 0, 0, 'h0000,  0, 'h0000,  'h0000,  0, 0};
    tbl[6]  = '{0, 1, 0, 0, 'h0000,  0, 'h0000,  'h0000,  0, 1};
    tbl[7]  = '{0, 0, 1, 0, 'h0000,  0, 'h0000,  'h0000,  0, 0};
    tbl[8]  = '{1, 1, 0, 0, 'h0222,  1, 'h0222,  'h0000,  0, 0};
    tbl[9]  = '{1, 1, 1, 0, 'h0333,  0, 'h0000,  'h0000,  0, 0};
    tbl[10] = '{1, 0, 0, 0, 'h0BBB,  1, 'h0BBB,  'h0000,  0, 0};
    tbl[11] = '{1, 0, 0, 0, 'h0AAA,  2, 'h0AAA,  'h0BBB,  0, 0};
    tbl[12] = '{1, 1, 0, 0, 'h1555,  2, 'h1555,  'h0BBB,  0, 0};
    tbl[13] = '{1, 0, 0, 1, 'h3FFF,  2, 'h1555,  'h0BBB,  0, 0};
    tbl[14] = '{0, 0, 1, 1, 'h0000,  2, 'h1555,  'h0BBB,  0, 0};
    tbl[15] = '{0, 1, 0, 1, 'h0000,  2, 'h1555,  'h0BBB,  0, 0};
    tbl[16] = '{1, 0, 0, 0, 'h3FFF,  3, 'h3FFF,  'h1555,  0, 0};
    tbl[17] = '{0, 1, 0, 0, 'h0000,  2, 'h1555,  'h0BBB,  0, 0};
    tbl[18] = '{0, 0, 1, 0, 'h0000,  0, 'h0000,  'h0000,  0, 0};

    drive(0, 0, 0, 0, 0);
    #12;
    check_out("reset", z);
    @(negedge PCSCLK);
    T_RST = 1'b0;

    for (int i = 0; i < 19; i++)
      step($sformatf("vec%0d", i), tbl[i].pu, tbl[i].po, tbl[i].cl, tbl[i].ce, tbl[i].din,
           tbl[i].cnt, tbl[i].top, tbl[i].ntop, tbl[i].ovf, tbl[i].unf);

    // fill to full, replace top at full, then overflow
    for (int k = 1; k <= DEPTH; k++)
      step($sformatf("fill%0d", k), 1, 0, 0, 0, 'h100 + k,
           k, 'h100 + k, (k >= 2) ? 'h100 + k - 1 : 0, 0, 0);
    step("repl_full", 1, 1, 0, 0, 'h2AAA, DEPTH, 'h2AAA, 'h10F, 0, 0);
    step("ovf",       1, 0, 0, 0, 'h0777, DEPTH, 'h2AAA, 'h10F, 1, 0);
    step("pop_full",  0, 1, 0, 0, 'h0000, DEPTH - 1, 'h10F, 'h10E, 1, 0);
    step("ovf_clr",   0, 0, 1, 0, 'h0000, 0, 0, 0, 0, 0);

    // asynchronous reset in the middle of a push burst at count 5
    for (int k = 1; k <= 5; k++)
      step($sformatf("burst%0d", k), 1, 0, 0, 0, 'h200 + k,
           k, 'h200 + k, (k >= 2) ? 'h200 + k - 1 : 0, 0, 0);
    drive(1, 0, 0, 0, 'h0999);
    #2;
    T_RST = 1'b1;
    #1;
    check_out("async_rst", z);
`ifdef PCSTK_DBG_EN
    dbg_addr = 4'd4;
    #1;
    chk("dbg_mem4", int'(dbg_data), 'h205);
`endif
    @(posedge PCSCLK);
    #1;
    check_out("rst_hold", z);
`ifdef PCSTK_DBG_EN
    dbg_addr = 4'd0;
    #1;
    chk("dbg_mem0_no_write", int'(dbg_data), 'h201);
`endif
    drive(0, 0, 0, 0, 0);
    @(negedge PCSCLK);
    T_RST = 1'b0;
    step("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("post_rst_push", 1, 0, 0, 0, 'h0042, 1, 'h0042, 0, 0, 0);

    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pc_stack_gen.md
Name: pc_stack_gen

Overview:
Parametrised hardware return-address stack for the PSQ program sequencer; next generation of the 16x14 PC stack.
- Adds configurable width and depth, a simultaneous push+pop "replace top" operation, and synchronous flush.
- Adds sticky overflow/underflow error flags, an occupancy count and an almost-full watermark.
- Top and next-of-top read data are defined (zero) when the stack holds too few entries.
- Sits between the PC generation logic and the call/return/loop control in PSQ.

Parameters:
DW, 14, data width (PC width)
DEPTH, 16, number of entries, power of two, minimum 2
AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
CW, $clog2(DEPTH)+1, count width (derived, not overridden)

Ports:
PCSCLK  in  1  stack clock
T_RST  in  1  asynchronous active-high reset
ckenb  in  1  active-high clock-enable inhibit; when 1, no state changes
push  in  1  push request
pop  in  1  pop request
clr  in  1  synchronous flush
din  in  DW  data to push
top  out  DW  entry at count-1; 0 when empty
ntop  out  DW  entry at count-2; 0 when count < 2
count  out  CW  number of valid entries, 0..DEPTH
empty  out  1  count == 0
full  out  1  count == DEPTH
has1  out  1  count == 1
almost_full  out  1  count >= AF_LEVEL
ovf_err  out  1  sticky: push attempted while full
unf_err  out  1  sticky: pop attempted while empty

Behaviour:
- Interface: reset T_RST, asynchronous, active-high; clock PCSCLK.
- All state updates occur on the PCSCLK rising edge when ckenb == 0.
- Reset values: count = 0, ovf_err = 0, unf_err = 0. Hence top = 0, ntop = 0, empty = 1, full = 0, has1 = 0, almost_full = 0. Storage contents are not reset.
- Priority when ckenb == 0: clr, then push&pop, then push, then pop.
- clr: count <- 0; ovf_err <- 0; unf_err <- 0; push and pop are ignored.
- push only, not full: mem[count] <- din; count <- count+1.
- push only, full: no write; count unchanged; ovf_err <- 1.
- pop only, not empty: count <- count-1. Storage is unchanged.
- pop only, empty: count stays 0; unf_err <- 1.
- push & pop, count >= 1: replace top: mem[count-1] <- din; count unchanged; no error, including when full.
- push & pop, count == 0: behaves as push only (mem[0] <- din, count <- 1); no unf_err.
- Reads (top, ntop) are combinational from count and storage.
  - Pushed data appears on top in the cycle after the edge; there is no same-cycle bypass of din.
  - After a pop, the old ntop appears on top in the next cycle.
- count never wraps. It saturates at 0 and DEPTH by the rules above.
- Flags are decoded combinationally from count and change only with count.
- ckenb == 1 freezes count, storage and error flags, regardless of push, pop and clr.
- T_RST asserted mid-operation: count and errors clear immediately (asynchronously); any in-flight write is dropped.

Optional Feature:
Macro PCSTK_DBG_EN.
- Defined: adds debug ports dbg_addr (in, CW-1 bits) and dbg_data (out, DW bits).
  - dbg_data = mem[dbg_addr], combinational, for any entry regardless of count.
  - No effect on stack state.
- Not defined: the ports are absent and the storage has only the top/ntop read ports.

Decomposition:
- Shared PSQ package holds:
  - PCSTK_DW_DEF = 14, PCSTK_DEPTH_DEF = 16, PCSTK_AF_DEF = 14.
  - The operation-decode encoding: OP_NONE, OP_PUSH, OP_POP, OP_REPL, OP_CLR.
- One sub-module: pc_stack_ram, a DEPTH x DW register file.
  - One synchronous write port (we, wa, wd).
  - Two or three combinational read ports (third only with PCSTK_DBG_EN).
  - No reset.
- Pointer/count, flags and zero-masking of top/ntop live in pc_stack_gen.

Test Plan:
- Reset, then push 0x0123, 0x0456, 0x0789 -> count = 3, top = 0x0789, ntop = 0x0456, has1 = 0; then pop twice -> top = 0x0123, ntop = 0, has1 = 1.
- Push 17 values with DEPTH = 16 -> full = 1 after the 16th push, almost_full = 1 from count 14; 17th push sets ovf_err = 1, count stays 16, top = 16th value.
- From empty, pop -> unf_err = 1, count = 0, top = 0; then clr -> unf_err = 0.
- count = 2 (top = 0x0AAA), push & pop with din = 0x1555 -> count = 2, top = 0x1555, ntop unchanged. When full, the same operation replaces top with no ovf_err.
- Hold ckenb = 1 while driving push with din = 0x3FFF -> count, top and errors unchanged. Release ckenb -> the push takes effect on the next edge.
- Assert T_RST asynchronously mid-burst at count = 5 -> count = 0, empty = 1 immediately without a clock. With PCSTK_DBG_EN, dbg_addr = 4 still returns the value written before reset.
